db9_md_scanner: RTL and testbench

Sequencer that owns the DB9 select line and scans a Mega Drive style pad once per video frame, producing a debounced-by-burst 12-bit button word for the arcade input mapping. It sits between the raw DB9 pins (CB UDLR, negative logic) and the per-player control merge in the core top level. It replaces free-running select toggling with a frame-locked burst so every frame sees one coherent snapshot.

---
 rtl/db9_pkg.sv | 32 +++
 rtl/db9_sync2.sv | 32 +++
 rtl/db9_md_scanner.sv | 189 ++++++++++++++++++
 tb/tb_db9_md_scanner.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/db9_pkg.sv
// db9_pkg: state encoding and bit positions shared by the DB9 Mega Drive scanner.
package db9_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } db9_state_e;

    // joy_o bit positions, word is {M,X,Y,Z,S,A,C,B,R,L,D,U}
    localparam int J_U = 0;
    localparam int J_D = 1;
    localparam int J_L = 2;
    localparam int J_R = 3;
    localparam int J_B = 4;
    localparam int J_C = 5;
    localparam int J_A = 6;
    localparam int J_S = 7;
    localparam int J_Z = 8;
    localparam int J_Y = 9;
    localparam int J_X = 10;
    localparam int J_M = 11;

    // joy_i_db9 pin positions, pins are {C,B,U,D,L,R}
    localparam int P_R = 0;
    localparam int P_L = 1;
    localparam int P_D = 2;
    localparam int P_U = 3;
    localparam int P_B = 4;
    localparam int P_C = 5;

endpackage

// File: rtl/db9_sync2.sv
// db9_sync2: two-flop synchronizer for the six raw DB9 pins.
// Resets to all ones so a released pad (negative logic) is seen until real data arrives.
module db9_sync2 (
    input  logic       clk_sys,
    input  logic       RESET,
    input  logic [5:0] d,
    output logic [5:0] q
);

    logic [5:0] meta_q, meta_d;
    logic [5:0] sync_q, sync_d;

    // shift the pins one stage per clock
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // synchronizer flops
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/db9_md_scanner.sv
// db9_md_scanner: frame-locked select burst for a Mega Drive pad on a DB9 port.
// Optional six-button support is enabled by defining DB9_MD_SIX_BUTTON_EN
// (8-phase burst); without it the burst is 4 phases and X/Y/Z/M read released.
//
// state  | meaning
// IDLE   | select held high, waiting for frame strobe
// SCAN   | phase p = 0..last, select = ~p[0], sample on the phase's final tick
// COMMIT | one cycle: shadow copied to joy_o, valid pulsed
module db9_md_scanner
    import db9_pkg::*;
#(
    parameter int PHASE_TICKS = 1
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        tick,
    input  logic        frame,
    input  logic [5:0]  joy_i_db9,
    output logic        db9_select,
    output logic [11:0] joy_o,
    output logic        pad_present,
    output logic        pad_6btn,
    output logic        valid
);

    localparam int TW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LOAD = TW'(PHASE_TICKS - 1);
`ifdef DB9_MD_SIX_BUTTON_EN
    localparam logic [2:0] LAST_PHASE = 3'd7;
`else
    localparam logic [2:0] LAST_PHASE = 3'd3;
`endif

    db9_state_e    state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [11:0]   shadow_q, shadow_d;
    logic          present_q, present_d;
    logic          six_q, six_d;
    logic          sel_q, sel_d;
    logic [11:0]   joy_q, joy_d;
    logic          pad_present_q, pad_present_d;
    logic          pad_6btn_q, pad_6btn_d;
    logic          valid_q, valid_d;
    logic [5:0]    pins_s;
    logic          phase_end;

    db9_sync2 u_sync (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .d       (joy_i_db9),
        .q       (pins_s)
    );

    // tick down-counter reaches terminal count on the phase's last tick
    assign phase_end = tick && (tcnt_q == '0);

    // next-state, sampling and commit logic
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        tcnt_d        = tcnt_q;
        shadow_d      = shadow_q;
        present_d     = present_q;
        six_d         = six_q;
        sel_d         = sel_q;
        joy_d         = joy_q;
        pad_present_d = pad_present_q;
        pad_6btn_d    = pad_6btn_q;
        valid_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_d = 1'b1;
                if (frame) begin
                    state_d   = ST_SCAN;
                    phase_d   = '0;
                    tcnt_d    = TICK_LOAD;
                    shadow_d  = '1;
                    present_d = 1'b0;
                    six_d     = 1'b0;
                end
            end

            ST_SCAN: begin
                if (phase_end) begin
                    case (phase_q)
                        3'd0: begin
                            shadow_d[J_U] = pins_s[P_U];
                            shadow_d[J_D] = pins_s[P_D];
                            shadow_d[J_L] = pins_s[P_L];
                            shadow_d[J_R] = pins_s[P_R];
                            shadow_d[J_B] = pins_s[P_B];
                            shadow_d[J_C] = pins_s[P_C];
                        end
                        3'd1: begin
                            shadow_d[J_A] = pins_s[P_B];
                            shadow_d[J_S] = pins_s[P_C];
                            present_d     = ~pins_s[P_L] & ~pins_s[P_R];
                        end
`ifdef DB9_MD_SIX_BUTTON_EN
                        3'd5: begin
                            six_d = present_q & ~(pins_s[P_U] | pins_s[P_D] |
                                                  pins_s[P_L] | pins_s[P_R]);
                        end
                        3'd6: begin
                            if (six_q) begin
                                shadow_d[J_Z] = pins_s[P_U];
                                shadow_d[J_Y] = pins_s[P_D];
                                shadow_d[J_X] = pins_s[P_L];
                                shadow_d[J_M] = pins_s[P_R];
                            end
                        end
`endif
                        default: ;
                    endcase

                    if (phase_q == LAST_PHASE) begin
                        state_d = ST_COMMIT;
                        sel_d   = 1'b1;
                    end else begin
                        phase_d = phase_q + 3'd1;
                        tcnt_d  = TICK_LOAD;
                        // next phase is odd (select low) exactly when this one is even
                        sel_d   = phase_q[0];
                    end
                end else if (tick) begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end

            ST_COMMIT: begin
                joy_d = shadow_q;
                if (!present_q) begin
                    joy_d[J_A] = 1'b1;
                    joy_d[J_S] = 1'b1;
                end
                if (!six_q) begin
                    joy_d[J_Z] = 1'b1;
                    joy_d[J_Y] = 1'b1;
                    joy_d[J_X] = 1'b1;
                    joy_d[J_M] = 1'b1;
                end
                pad_present_d = present_q;
                pad_6btn_d    = six_q;
                valid_d       = 1'b1;
                state_d       = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            tcnt_q        <= '0;
            shadow_q      <= '1;
            present_q     <= 1'b0;
            six_q         <= 1'b0;
            sel_q         <= 1'b1;
            joy_q         <= '1;
            pad_present_q <= 1'b0;
            pad_6btn_q    <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            tcnt_q        <= tcnt_d;
            shadow_q      <= shadow_d;
            present_q     <= present_d;
            six_q         <= six_d;
            sel_q         <= sel_d;
            joy_q         <= joy_d;
            pad_present_q <= pad_present_d;
            pad_6btn_q    <= pad_6btn_d;
            valid_q       <= valid_d;
        end
    end

    assign db9_select  = sel_q;
    assign joy_o       = joy_q;
    assign pad_present = pad_present_q;
    assign pad_6btn    = pad_6btn_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_db9_md_scanner.sv
// Bench for db9_md_scanner: behavioural Mega Drive pad model driving the pins,
// expected snapshots derived from held buttons and pad type.
module tb_db9_md_scanner;

    localparam int PT       = 3;
    localparam int TICK_DIV = 5;
`ifdef DB9_MD_SIX_BUTTON_EN
    localparam int NPH    = 8;
    localparam bit SIX_EN = 1'b1;
`else
    localparam int NPH    = 4;
    localparam bit SIX_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic        tick;
    logic        frame;
    logic [5:0]  joy_i_db9;
    logic        db9_select;
    logic [11:0] joy_o;
    logic        pad_present;
    logic        pad_6btn;
    logic        valid;

    int          pad_type = 0;     // 0 none, 1 three-button, 2 six-button
    logic [11:0] btn_n = 12'hFFF;  // held buttons, {M,X,Y,Z,S,A,C,B,R,L,D,U}, 0 = pressed
    int          low_cnt = 0;
    int          low_base = 0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          tick_total = 0;
    int          valid_cnt = 0;
    int          valid_tick = 0;
    int          t_start = 0;
    int          v_start = 0;
    int          hist_base = 0;
    int          tick_div = 0;
    logic [11:0] joy_v = 12'h000;
    logic        pres_v = 1'b0;
    logic        six_v = 1'b0;
    logic        sel_neg = 1'b1;
    logic        sel_hist[$];
    logic [11:0] last_exp = 12'hFFF;

    db9_md_scanner #(.PHASE_TICKS(PT)) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .tick        (tick),
        .frame       (frame),
        .joy_i_db9   (joy_i_db9),
        .db9_select  (db9_select),
        .joy_o       (joy_o),
        .pad_present (pad_present),
        .pad_6btn    (pad_6btn),
        .valid       (valid)
    );

    always #5 clk_sys = ~clk_sys;

    // pad: select high gives U,D,L,R,B,C; low gives U,D,0,0,A,Start.
    // A six-button pad on its third low reports U..R = 0, and on the
    // following high reports Z,Y,X,Mode on U,D,L,R.
    function automatic logic [5:0] pad_pins(input int typ, input logic [11:0] b,
                                            input logic sel, input int cnt);
        logic six_mode;
        if (typ == 0) return 6'h3F;
        six_mode = (typ == 2) && (cnt == 3);
        if (sel === 1'b1) begin
            if (six_mode) return {b[5], b[4], b[8], b[9], b[10], b[11]};
            return {b[5], b[4], b[0], b[1], b[2], b[3]};
        end
        if (six_mode) return {b[7], b[6], 4'b0000};
        return {b[7], b[6], b[0], b[1], 2'b00};
    endfunction

    function automatic logic [11:0] exp_joy(input int typ, input logic [11:0] b);
        if (typ == 0) return 12'hFFF;
        if (typ == 2 && SIX_EN) return b;
        return b | 12'hF00;
    endfunction

    function automatic logic [11:0] rand_btn();
        logic [11:0] b;
        b = 12'($urandom);
        if (!b[0] && !b[1]) b[1] = 1'b1;  // up+down cannot be held together
        return b;
    endfunction

    assign joy_i_db9 = pad_pins(pad_type, btn_n, db9_select, low_cnt - low_base);

    always @(negedge db9_select) low_cnt = low_cnt + 1;

    always @(negedge clk_sys) sel_neg = db9_select;

    always @(posedge clk_sys) begin
        if (tick === 1'b1) begin
            tick_total = tick_total + 1;
            sel_hist.push_back(sel_neg);
        end
        #1;
        if (valid === 1'b1) begin
            valid_cnt  = valid_cnt + 1;
            valid_tick = tick_total;
            joy_v      = joy_o;
            pres_v     = pad_present;
            six_v      = pad_6btn;
        end
    end

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk_sys);
            tick_div = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
            tick = (tick_div == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

    task automatic start_burst(input bit coinc);
        int guard;
        guard = 0;
        low_base = low_cnt;
        @(negedge clk_sys); #1;
        while (tick !== coinc && guard < 50) begin
            @(negedge clk_sys); #1;
            guard++;
        end
        v_start = valid_cnt;
        frame = 1'b1;
        @(posedge clk_sys); #1;
        t_start   = tick_total;
        hist_base = sel_hist.size();
        @(negedge clk_sys); #1;
        frame = 1'b0;
    endtask

    task automatic do_burst(input bit coinc, input int extra, output bit to);
        int guard;
        guard = 0;
        start_burst(coinc);
        to = 1'b0;
        while (valid_cnt == v_start) begin
            if (guard >= 1000) begin
                to = 1'b1;
                break;
            end
            frame = (extra > 0) && (guard % 9 == 4) && (guard < 9 * extra);
            @(negedge clk_sys); #1;
            guard++;
        end
        frame = 1'b0;
        repeat (15) @(negedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        frame = 1'b0;
        pad_type = 0;
        btn_n = 12'hFFF;
        repeat (3) @(posedge clk_sys);
        #1;
        n_checks++;
        if (db9_select !== 1'b1) begin
            n_errors++; $display("FAIL reset_select: got %b want 1", db9_select);
        end
        n_checks++;
        if (joy_o !== 12'hFFF) begin
            n_errors++; $display("FAIL reset_joy: got %h want fff", joy_o);
        end
        n_checks++;
        if (pad_present !== 1'b0 || pad_6btn !== 1'b0 || valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got present=%b six=%b valid=%b want 0 0 0",
                     pad_present, pad_6btn, valid);
        end
        @(negedge clk_sys);
        RESET = 1'b0;
        repeat (60) @(negedge clk_sys);
        #1;
        n_checks++;
        if (valid_cnt !== 0) begin
            n_errors++; $display("FAIL idle_no_valid: got %0d pulses want 0", valid_cnt);
        end
        n_checks++;
        if (db9_select !== 1'b1 || joy_o !== 12'hFFF) begin
            n_errors++;
            $display("FAIL idle_outputs: got select=%b joy=%h want 1 fff", db9_select, joy_o);
        end
    endtask

    task automatic test_snapshots();
        int          typ;
        int          bad;
        logic [11:0] b;
        logic [11:0] exp_j;
        bit          to;
        for (int s = 0; s < 15; s++) begin
            case (s)
                0: begin typ = 1; b = 12'hFFF; b[6] = 1'b0; b[0] = 1'b0; end   // A + Up
                1: begin typ = 2; b = 12'hFFF; b[8] = 1'b0; b[7] = 1'b0; end   // Z + Start
                2: begin typ = 0; b = rand_btn(); end
                default: begin typ = $urandom_range(0, 2); b = rand_btn(); end
            endcase
            pad_type = typ;
            btn_n    = b;
            exp_j    = exp_joy(typ, b);
            do_burst(1'b0, 0, to);

            n_checks++;
            if (to) begin
                n_errors++; $display("FAIL snap%0d_timeout: no valid within 1000 cycles", s);
            end
            n_checks++;
            if (valid_cnt - v_start !== 1) begin
                n_errors++; $display("FAIL snap%0d_valid_count: got %0d want 1", s, valid_cnt - v_start);
            end
            n_checks++;
            if (joy_v !== exp_j) begin
                n_errors++;
                $display("FAIL snap%0d_joy: type %0d buttons %h got %h want %h", s, typ, b, joy_v, exp_j);
            end
            n_checks++;
            if (pres_v !== (typ != 0)) begin
                n_errors++; $display("FAIL snap%0d_present: got %b want %b", s, pres_v, typ != 0);
            end
            n_checks++;
            if (six_v !== (typ == 2 && SIX_EN)) begin
                n_errors++; $display("FAIL snap%0d_six: got %b want %b", s, six_v, typ == 2 && SIX_EN);
            end
            n_checks++;
            if (valid_tick - t_start !== NPH * PT) begin
                n_errors++;
                $display("FAIL snap%0d_burst_ticks: got %0d want %0d", s, valid_tick - t_start, NPH * PT);
            end
            bad = 0;
            if (sel_hist.size() < hist_base + NPH * PT) bad = -1;
            else begin
                for (int k = 0; k < NPH * PT; k++)
                    if (sel_hist[hist_base + k] !== ((k / PT) % 2 == 0)) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_errors++; $display("FAIL snap%0d_select_seq: got %0d bad ticks want 0", s, bad);
            end
            n_checks++;
            if (db9_select !== 1'b1) begin
                n_errors++; $display("FAIL snap%0d_idle_select: got %b want 1", s, db9_select);
            end
            n_checks++;
            if (joy_o !== exp_j) begin
                n_errors++; $display("FAIL snap%0d_joy_held: got %h want %h", s, joy_o, exp_j);
            end
            last_exp = exp_j;
        end
    endtask

    task automatic test_hold();
        int v0;
        v0 = valid_cnt;
        for (int i = 0; i < 20; i++) begin
            pad_type = $urandom_range(0, 2);
            btn_n    = rand_btn();
            repeat (25) @(negedge clk_sys);
        end
        #1;
        n_checks++;
        if (joy_o !== last_exp) begin
            n_errors++; $display("FAIL hold_joy: got %h want %h", joy_o, last_exp);
        end
        n_checks++;
        if (valid_cnt !== v0) begin
            n_errors++; $display("FAIL hold_valid: got %0d pulses want 0", valid_cnt - v0);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] b;
        logic [11:0] exp_j;
        bit          to;
        for (int r = 0; r < 2; r++) begin
            b = rand_btn();
            b[0] = 1'b0;
            b[1] = 1'b1;
            pad_type = 2;
            btn_n    = b;
            exp_j    = exp_joy(2, b);
            do_burst(1'b1, 3 - r, to);
            n_checks++;
            if (to) begin
                n_errors++; $display("FAIL b2b%0d_timeout: no valid within 1000 cycles", r);
            end
            n_checks++;
            if (valid_cnt - v_start !== 1) begin
                n_errors++; $display("FAIL b2b%0d_valid_count: got %0d want 1", r, valid_cnt - v_start);
            end
            n_checks++;
            if (valid_tick - t_start !== NPH * PT) begin
                n_errors++;
                $display("FAIL b2b%0d_burst_ticks: got %0d want %0d", r, valid_tick - t_start, NPH * PT);
            end
            n_checks++;
            if (joy_v !== exp_j) begin
                n_errors++; $display("FAIL b2b%0d_joy: got %h want %h", r, joy_v, exp_j);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int          guard;
        int          v0;
        logic [11:0] b;
        logic [11:0] exp_j;
        bit          to;
        pad_type = 2;
        btn_n    = rand_btn();
        start_burst(1'b0);
        v0 = v_start;
        guard = 0;
        while (sel_hist.size() < hist_base + (NPH / 2) * PT && guard < 1000) begin
            @(negedge clk_sys); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 1000) begin
            n_errors++; $display("FAIL midreset_reach_phase: got no phase %0d want reached", NPH / 2);
        end
        RESET = 1'b1;
        @(posedge clk_sys); #1;
        n_checks++;
        if (db9_select !== 1'b1 || joy_o !== 12'hFFF) begin
            n_errors++;
            $display("FAIL midreset_outputs: got select=%b joy=%h want 1 fff", db9_select, joy_o);
        end
        n_checks++;
        if (pad_present !== 1'b0 || pad_6btn !== 1'b0 || valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_flags: got present=%b six=%b valid=%b want 0 0 0",
                     pad_present, pad_6btn, valid);
        end
        @(negedge clk_sys); #1;
        RESET = 1'b0;
        repeat (300) @(negedge clk_sys);
        #1;
        n_checks++;
        if (valid_cnt !== v0 || joy_o !== 12'hFFF) begin
            n_errors++;
            $display("FAIL midreset_discard: got %0d pulses joy=%h want 0 fff", valid_cnt - v0, joy_o);
        end
        b = rand_btn();
        b[6] = 1'b0;
        pad_type = 1;
        btn_n    = b;
        exp_j    = exp_joy(1, b);
        do_burst(1'b0, 0, to);
        n_checks++;
        if (to || valid_cnt - v_start !== 1) begin
            n_errors++;
            $display("FAIL midreset_next_valid: got timeout=%b pulses=%0d want 0 1", to, valid_cnt - v_start);
        end
        n_checks++;
        if (joy_v !== exp_j || pres_v !== 1'b1 || six_v !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_next_data: got joy=%h present=%b six=%b want %h 1 0",
                     joy_v, pres_v, six_v, exp_j);
        end
    endtask

    initial begin
        RESET = 1'b1;
        frame = 1'b0;
        test_reset();
        test_snapshots();
        test_hold();
        test_back_to_back();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
